// File: rtl/idu_if.sv
// Decode-stage bundle: fetch inputs, exu controls, regfile/writeback ports and decode results.
// The slave modport is the decoder's view; the master modport drives it.
interface idu_if;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        jump_valid_i;
    logic        hold_valid_i;
    logic [4:0]  rs1_addr_o;
    logic [4:0]  rs2_addr_o;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        wb_we_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic [31:0] imm_o;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic [4:0]  rd_addr_o;
    logic        rd_we_o;
    logic [3:0]  op_class_o;
    logic [2:0]  funct3_o;
    logic        funct7b5_o;
    logic        illegal_o;

    modport slave (
        input  instr_i, pc_i, jump_valid_i, hold_valid_i, rs1_data_i, rs2_data_i,
               wb_we_i, wb_addr_i, wb_data_i,
        output rs1_addr_o, rs2_addr_o, valid_o, pc_o, instr_o, imm_o, rs1_data_o,
               rs2_data_o, rd_addr_o, rd_we_o, op_class_o, funct3_o, funct7b5_o, illegal_o
    );

    modport master (
        output instr_i, pc_i, jump_valid_i, hold_valid_i, rs1_data_i, rs2_data_i,
               wb_we_i, wb_addr_i, wb_data_i,
        input  rs1_addr_o, rs2_addr_o, valid_o, pc_o, instr_o, imm_o, rs1_data_o,
               rs2_data_o, rd_addr_o, rd_we_o, op_class_o, funct3_o, funct7b5_o, illegal_o
    );
endinterface

// File: rtl/idu.sv
// RV32I instruction decode stage: one register stage between fetch and execute with
// writeback bypass, post-jump squashing and exu-driven hold.
module idu #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input logic clk,
    input logic rst,
    idu_if.slave bus
);
    localparam int unsigned    SQ_W    = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(FLUSH_CYCLES);

    localparam logic [3:0] OPC_LUI    = 4'd0;
    localparam logic [3:0] OPC_AUIPC  = 4'd1;
    localparam logic [3:0] OPC_JAL    = 4'd2;
    localparam logic [3:0] OPC_JALR   = 4'd3;
    localparam logic [3:0] OPC_BRANCH = 4'd4;
    localparam logic [3:0] OPC_LOAD   = 4'd5;
    localparam logic [3:0] OPC_STORE  = 4'd6;
    localparam logic [3:0] OPC_OPIMM  = 4'd7;
    localparam logic [3:0] OPC_OP     = 4'd8;
    localparam logic [3:0] OPC_FENCE  = 4'd9;
    localparam logic [3:0] OPC_SYSTEM = 4'd10;
    localparam logic [3:0] OPC_NOP    = 4'd15;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [4:0]  rd_addr;
        logic        rd_we;
        logic [3:0]  op_class;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        illegal;
    } dec_t;

    function automatic logic [31:0] imm_i_type(input logic [11:0] f);
        return {{20{f[11]}}, f};
    endfunction

    function automatic logic [31:0] imm_s_type(input logic [6:0] hi, input logic [4:0] lo);
        return {{20{hi[6]}}, hi, lo};
    endfunction

    function automatic logic [31:0] imm_b_type(input logic [6:0] hi, input logic [4:0] lo);
        return {{19{hi[6]}}, hi[6], lo[0], hi[5:0], lo[4:1], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u_type(input logic [19:0] f);
        return {f, 12'd0};
    endfunction

    function automatic logic [31:0] imm_j_type(input logic [19:0] f);
        return {{11{f[19]}}, f[19], f[7:0], f[8], f[18:9], 1'b0};
    endfunction

    // x0 reads as zero; a same-cycle writeback to the source register wins over the regfile.
    function automatic logic [31:0] read_operand(input logic [4:0] addr, input logic [31:0] rf_data,
                                                 input logic wb_we, input logic [4:0] wb_addr,
                                                 input logic [31:0] wb_data);
        if (addr == 5'd0) begin
            return 32'd0;
        end else if (wb_we && (wb_addr == addr)) begin
            return wb_data;
        end else begin
            return rf_data;
        end
    endfunction

    function automatic dec_t bubble(input logic [31:0] pc);
        dec_t b;
        b          = '0;
        b.pc       = pc;
        b.instr    = NOP_INSTR;
        b.op_class = OPC_NOP;
        return b;
    endfunction

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [4:0]      rd_s;
    logic [3:0]      class_raw_s;
    logic [31:0]     imm_raw_s;
    logic            op_bad_s;
    logic            illegal_s;
    logic            rd_we_s;
    dec_t            decoded_s;
    dec_t            dec_nxt_s;
    dec_t            dec_r;
    logic [SQ_W-1:0] sq_nxt_s;
    logic [SQ_W-1:0] sq_cnt_r;

    assign opcode_s       = bus.instr_i[6:0];
    assign funct3_s       = bus.instr_i[14:12];
    assign funct7_s       = bus.instr_i[31:25];
    assign rd_s           = bus.instr_i[11:7];
    assign bus.rs1_addr_o = bus.instr_i[19:15];
    assign bus.rs2_addr_o = bus.instr_i[24:20];

    // Opcode classification, immediate selection and legality of the current instr_i.
    always_comb begin
        class_raw_s = OPC_NOP;
        imm_raw_s   = 32'd0;
        op_bad_s    = 1'b0;
        case (opcode_s)
            7'b0110111: begin class_raw_s = OPC_LUI;    imm_raw_s = imm_u_type(bus.instr_i[31:12]); end
            7'b0010111: begin class_raw_s = OPC_AUIPC;  imm_raw_s = imm_u_type(bus.instr_i[31:12]); end
            7'b1101111: begin class_raw_s = OPC_JAL;    imm_raw_s = imm_j_type(bus.instr_i[31:12]); end
            7'b1100111: begin class_raw_s = OPC_JALR;   imm_raw_s = imm_i_type(bus.instr_i[31:20]); end
            7'b1100011: begin class_raw_s = OPC_BRANCH; imm_raw_s = imm_b_type(funct7_s, rd_s); end
            7'b0000011: begin class_raw_s = OPC_LOAD;   imm_raw_s = imm_i_type(bus.instr_i[31:20]); end
            7'b0100011: begin class_raw_s = OPC_STORE;  imm_raw_s = imm_s_type(funct7_s, rd_s); end
            7'b0010011: begin class_raw_s = OPC_OPIMM;  imm_raw_s = imm_i_type(bus.instr_i[31:20]); end
            7'b0110011: begin class_raw_s = OPC_OP;     imm_raw_s = 32'd0; end
            7'b0001111: begin class_raw_s = OPC_FENCE;  imm_raw_s = imm_i_type(bus.instr_i[31:20]); end
            7'b1110011: begin class_raw_s = OPC_SYSTEM; imm_raw_s = imm_i_type(bus.instr_i[31:20]); end
            default:    begin class_raw_s = OPC_NOP;    imm_raw_s = 32'd0; end
        endcase

        // Only ADD/SUB and SRL/SRA may carry funct7 = 0x20 among the base OP encodings.
        if (class_raw_s != OPC_OP) begin
            op_bad_s = 1'b0;
        end else if ((funct7_s != 7'h00) && (funct7_s != 7'h20)) begin
            op_bad_s = 1'b1;
        end else if ((funct7_s == 7'h20) && (funct3_s != 3'b000) && (funct3_s != 3'b101)) begin
            op_bad_s = 1'b1;
        end else begin
            op_bad_s = 1'b0;
        end
    end

    assign illegal_s = (class_raw_s == OPC_NOP) || op_bad_s;

    // Destination write enable for the classes that produce a register result.
    always_comb begin
        rd_we_s = 1'b0;
        if (illegal_s) begin
            rd_we_s = 1'b0;
        end else begin
            case (class_raw_s)
                OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
                OPC_LOAD, OPC_OPIMM, OPC_OP: rd_we_s = (rd_s != 5'd0);
                default:                     rd_we_s = 1'b0;
            endcase
        end
    end

    // Assemble the full decode record for a normally advancing instruction.
    always_comb begin
        decoded_s          = '0;
        decoded_s.valid    = 1'b1;
        decoded_s.pc       = bus.pc_i;
        decoded_s.instr    = bus.instr_i;
        decoded_s.rs1_data = read_operand(bus.rs1_addr_o, bus.rs1_data_i, bus.wb_we_i,
                                          bus.wb_addr_i, bus.wb_data_i);
        decoded_s.rs2_data = read_operand(bus.rs2_addr_o, bus.rs2_data_i, bus.wb_we_i,
                                          bus.wb_addr_i, bus.wb_data_i);
        decoded_s.rd_addr  = rd_s;
        decoded_s.rd_we    = rd_we_s;
        decoded_s.funct3   = funct3_s;
        decoded_s.funct7b5 = funct7_s[5];
        decoded_s.illegal  = illegal_s;
        if (illegal_s) begin
            decoded_s.op_class = OPC_NOP;
            decoded_s.imm      = 32'd0;
        end else begin
            decoded_s.op_class = class_raw_s;
            decoded_s.imm      = imm_raw_s;
        end
    end

    // Load priority: jump, then hold, then pending squash, then the decoded instruction.
    always_comb begin
        dec_nxt_s = dec_r;
        sq_nxt_s  = sq_cnt_r;
        if (bus.jump_valid_i) begin
            dec_nxt_s = bubble(bus.pc_i);
            sq_nxt_s  = SQ_LOAD;
        end else if (bus.hold_valid_i) begin
            dec_nxt_s = dec_r;
            sq_nxt_s  = sq_cnt_r;
        end else if (sq_cnt_r != {SQ_W{1'b0}}) begin
            dec_nxt_s = bubble(bus.pc_i);
            sq_nxt_s  = sq_cnt_r - SQ_W'(1);
        end else begin
            dec_nxt_s = decoded_s;
            sq_nxt_s  = sq_cnt_r;
        end
    end

    // Pipeline register and squash counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_r    <= bubble(32'd0);
            sq_cnt_r <= {SQ_W{1'b0}};
        end else begin
            dec_r    <= dec_nxt_s;
            sq_cnt_r <= sq_nxt_s;
        end
    end

    assign bus.valid_o    = dec_r.valid;
    assign bus.pc_o       = dec_r.pc;
    assign bus.instr_o    = dec_r.instr;
    assign bus.imm_o      = dec_r.imm;
    assign bus.rs1_data_o = dec_r.rs1_data;
    assign bus.rs2_data_o = dec_r.rs2_data;
    assign bus.rd_addr_o  = dec_r.rd_addr;
    assign bus.rd_we_o    = dec_r.rd_we;
    assign bus.op_class_o = dec_r.op_class;
    assign bus.funct3_o   = dec_r.funct3;
    assign bus.funct7b5_o = dec_r.funct7b5;
    assign bus.illegal_o  = dec_r.illegal;
endmodule

// File: tb/tb_idu.sv
// Self-checking bench for idu: directed vector table, hand-written jump/hold/reset sequences,
// and randomized traffic against a behavioural decode model.
module tb_idu;
    localparam int          FLUSH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk;
    logic rst;
    idu_if bus ();

    idu #(.FLUSH_CYCLES(FLUSH), .NOP_INSTR(NOP)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        we;
        logic [3:0]  opc;
        logic [2:0]  f3;
        logic        f7b5;
        logic        ill;
    } out_t;

    typedef struct {
        logic [31:0] instr, pc, rs1d, rs2d;
        logic        wbwe;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        ev;
        logic [3:0]  eop;
        logic [4:0]  erd;
        logic        ewe;
        logic [31:0] eimm, ers1;
        logic        eill;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    logic [6:0] opcodes [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    int class_of [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};

    function automatic logic [31:0] opnd(logic [4:0] a, logic [31:0] rf, logic we, logic [4:0] wa, logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return rf;
    endfunction

    function automatic out_t ref_bubble(logic [31:0] pc);
        out_t o = '0;
        o.pc = pc; o.instr = NOP; o.opc = 4'd15;
        return o;
    endfunction

    function automatic out_t ref_decode(logic [31:0] ins, logic [31:0] pc, logic [31:0] r1, logic [31:0] r2,
                                        logic we, logic [4:0] wa, logic [31:0] wd);
        out_t o = '0;
        int cls = -1;
        int v = 0;
        logic [6:0] f7 = ins[31:25];
        logic [2:0] f3 = ins[14:12];
        for (int k = 0; k < 11; k++) if (opcodes[k] == ins[6:0]) cls = class_of[k];
        if (cls == 0 || cls == 1) v = int'(ins & 32'hFFFF_F000);
        else if (cls == 2) v = $signed({ins[31], ins[19:12], ins[20], ins[30:21]}) * 32'sd2;
        else if (cls == 4) v = $signed({ins[31], ins[7], ins[30:25], ins[11:8]}) * 32'sd2;
        else if (cls == 6) v = $signed({ins[31:25], ins[11:7]});
        else if (cls == 3 || cls == 5 || cls == 7 || cls == 9 || cls == 10) v = $signed(ins[31:20]);
        else v = 0;
        if (cls == 8 && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) cls = -1;
        o.valid = 1'b1; o.pc = pc; o.instr = ins;
        o.rs1 = opnd(ins[19:15], r1, we, wa, wd);
        o.rs2 = opnd(ins[24:20], r2, we, wa, wd);
        o.rd = ins[11:7]; o.f3 = f3; o.f7b5 = ins[30];
        if (cls < 0) begin
            o.ill = 1'b1; o.opc = 4'd15; o.imm = 32'd0; o.we = 1'b0;
        end else begin
            o.opc = 4'(cls); o.imm = v;
            o.we = (cls <= 3 || cls == 5 || cls == 7 || cls == 8) && (ins[11:7] != 5'd0);
        end
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o = {bus.valid_o, bus.pc_o, bus.instr_o, bus.imm_o, bus.rs1_data_o, bus.rs2_data_o,
             bus.rd_addr_o, bus.rd_we_o, bus.op_class_o, bus.funct3_o, bus.funct7b5_o, bus.illegal_o};
        return o;
    endfunction

    task automatic check_out(string name, out_t exp);
        out_t act = sample();
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(logic [31:0] ins, logic [31:0] pc, logic [31:0] r1, logic [31:0] r2, logic we,
                         logic [4:0] wa, logic [31:0] wd, logic j, logic h);
        bus.instr_i = ins; bus.pc_i = pc; bus.rs1_data_i = r1; bus.rs2_data_i = r2;
        bus.wb_we_i = we; bus.wb_addr_i = wa; bus.wb_data_i = wd;
        bus.jump_valid_i = j; bus.hold_valid_i = h;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1 check_out("reset_state", ref_bubble(32'd0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        int k = $urandom_range(0, 12);
        if (k < 11) r[6:0] = opcodes[k];
        if (k == 8 || k == 12) begin
            r[6:0] = 7'h33;
            case ($urandom_range(0, 2))
                0: r[31:25] = 7'h00;
                1: r[31:25] = 7'h20;
                default: r[31:25] = 7'($urandom);
            endcase
        end
        r[19:15] = 5'($urandom_range(0, 3));
        return r;
    endfunction

    vec_t vecs [15];
    out_t exp_r;
    out_t held;
    int   sq_m;

    initial begin
        vecs[0]  = '{32'h00500093, 32'h10, 32'd7, 32'd8, 1'b0, 5'd0, 32'd0, 1'b1, 4'd7,  5'd1,  1'b1, 32'd5,        32'd0, 1'b0};
        vecs[1]  = '{32'hFE000EE3, 32'h14, 32'd7, 32'd8, 1'b0, 5'd0, 32'd0, 1'b1, 4'd4,  5'd29, 1'b0, 32'hFFFFFFFC, 32'd0, 1'b0};
        vecs[2]  = '{32'h002081B3, 32'h18, 32'd7, 32'd8, 1'b1, 5'd1, 32'd9, 1'b1, 4'd8,  5'd3,  1'b1, 32'd0,        32'd9, 1'b0};
        vecs[3]  = '{32'h002001B3, 32'h1C, 32'd7, 32'd8, 1'b1, 5'd0, 32'd9, 1'b1, 4'd8,  5'd3,  1'b1, 32'd0,        32'd0, 1'b0};
        vecs[4]  = '{32'h002081B3, 32'h20, 32'd7, 32'd8, 1'b0, 5'd1, 32'd9, 1'b1, 4'd8,  5'd3,  1'b1, 32'd0,        32'd7, 1'b0};
        vecs[5]  = '{32'hFFFFFFFF, 32'h24, 32'd7, 32'd8, 1'b0, 5'd0, 32'd0, 1'b1, 4'd15, 5'd31, 1'b0, 32'd0,        32'd7, 1'b1};
        vecs[6]  = '{32'h407302B3, 32'h28, 32'd7, 32'd8, 1'b1, 5'd7, 32'd5, 1'b1, 4'd8,  5'd5,  1'b1, 32'd0,        32'd7, 1'b0};
        vecs[7]  = '{32'h407312B3, 32'h2C, 32'd7, 32'd8, 1'b0, 5'd0, 32'd0, 1'b1, 4'd15, 5'd5,  1'b0, 32'd0,        32'd7, 1'b1};
        vecs[8]  = '{32'h027302B3, 32'h30, 32'd7, 32'd8, 1'b0, 5'd0, 32'd0, 1'b1, 4'd15, 5'd5,  1'b0, 32'd0,        32'd7, 1'b1};
        vecs[9]  = '{32'h12345037, 32'h34, 32'd7, 32'd8, 1'b0, 5'd0, 32'd0, 1'b1, 4'd0,  5'd0,  1'b0, 32'h12345000, 32'd7, 1'b0};
        vecs[10] = '{32'hFE20AE23, 32'h38, 32'd7, 32'd8, 1'b1, 5'd1, 32'd9, 1'b1, 4'd6,  5'd28, 1'b0, 32'hFFFFFFFC, 32'd9, 1'b0};
        vecs[11] = '{32'h00000073, 32'h3C, 32'd7, 32'd8, 1'b0, 5'd0, 32'd0, 1'b1, 4'd10, 5'd0,  1'b0, 32'd0,        32'd0, 1'b0};
        vecs[12] = '{32'h008000EF, 32'h40, 32'd7, 32'd8, 1'b0, 5'd0, 32'd0, 1'b1, 4'd2,  5'd1,  1'b1, 32'd8,        32'd0, 1'b0};
        vecs[13] = '{32'h0FF0000F, 32'h44, 32'd7, 32'd8, 1'b0, 5'd0, 32'd0, 1'b1, 4'd9,  5'd0,  1'b0, 32'h000000FF, 32'd0, 1'b0};
        vecs[14] = '{32'hFFF12203, 32'h48, 32'd7, 32'd8, 1'b0, 5'd0, 32'd0, 1'b1, 4'd5,  5'd4,  1'b1, 32'hFFFFFFFF, 32'd7, 1'b0};

        rst = 1'b1;
        drive(32'h00500093, 32'h0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        do_reset();

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1d, vecs[i].rs2d, vecs[i].wbwe, vecs[i].wba, vecs[i].wbd, 1'b0, 1'b0);
            #1 check_val($sformatf("vec%0d_rs_addr", i), {22'd0, bus.rs1_addr_o, bus.rs2_addr_o},
                         {22'd0, vecs[i].instr[19:15], vecs[i].instr[24:20]});
            tick();
            check_val($sformatf("vec%0d_fields", i),
                      {bus.valid_o, bus.op_class_o, bus.rd_addr_o, bus.rd_we_o, bus.illegal_o} ^ 32'(bus.imm_o[3:0]) ^ 32'(bus.pc_o[7:0] << 16),
                      {vecs[i].ev, vecs[i].eop, vecs[i].erd, vecs[i].ewe, vecs[i].eill} ^ 32'(vecs[i].eimm[3:0]) ^ 32'(vecs[i].pc[7:0] << 16));
            check_val($sformatf("vec%0d_imm", i), bus.imm_o, vecs[i].eimm);
            check_val($sformatf("vec%0d_rs1", i), bus.rs1_data_o, vecs[i].ers1);
            @(negedge clk);
        end

        // Jump followed by three valid instructions: three bubbles, then real work.
        drive(32'h00500093, 32'h50, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        tick();
        check_out("jump_bubble", ref_bubble(32'h50));
        @(negedge clk); bus.jump_valid_i = 1'b0; bus.pc_i = 32'h54;
        tick(); check_val("squash1_valid", 32'(bus.valid_o), 32'd0);
        @(negedge clk); bus.pc_i = 32'h58;
        tick(); check_val("squash2_valid", 32'(bus.valid_o), 32'd0);
        @(negedge clk); bus.pc_i = 32'h5C;
        tick(); check_out("post_squash", ref_decode(32'h00500093, 32'h5C, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0));

        // Hold freezes the stage; a jump inside a hold still loads a bubble; hold freezes the counter.
        @(negedge clk); drive(32'h002081B3, 32'h60, 32'd7, 32'd8, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        held = ref_decode(32'h002081B3, 32'h60, 32'd7, 32'd8, 1'b0, 5'd0, 32'd0);
        tick(); check_out("pre_hold", held);
        @(negedge clk); drive(32'hFFFFFFFF, 32'h64, 32'd1, 32'd2, 1'b1, 5'd1, 32'd3, 1'b0, 1'b1);
        tick(); check_out("hold1", held);
        @(negedge clk); drive(32'h00500093, 32'h68, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        tick(); check_out("hold_jump", ref_bubble(32'h68));
        @(negedge clk); drive(32'h00500093, 32'h6C, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        tick(); check_out("hold_in_squash", ref_bubble(32'h68));
        @(negedge clk); drive(32'h00500093, 32'h70, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick(); check_out("release_sq1", ref_bubble(32'h70));
        @(negedge clk); bus.pc_i = 32'h74;
        tick(); check_out("release_sq2", ref_bubble(32'h74));
        @(negedge clk); drive(32'h002081B3, 32'h78, 32'd7, 32'd8, 1'b1, 5'd1, 32'd9, 1'b0, 1'b0);
        tick(); check_out("release_bypass", ref_decode(32'h002081B3, 32'h78, 32'd7, 32'd8, 1'b1, 5'd1, 32'd9));

        // Asynchronous reset in the middle of a squash clears both outputs and counter.
        @(negedge clk); drive(32'h00500093, 32'h80, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        tick();
        @(negedge clk); bus.jump_valid_i = 1'b0;
        tick();
        #1 rst = 1'b1;
        #1 check_out("async_reset", ref_bubble(32'd0));
        @(negedge clk); @(negedge clk); rst = 1'b0;
        bus.pc_i = 32'h84;
        tick(); check_out("after_reset", ref_decode(32'h00500093, 32'h84, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0));

        // Randomized traffic against the model, starting from a clean reset.
        do_reset();
        exp_r = ref_bubble(32'd0);
        sq_m  = 0;
        for (int c = 0; c < 600; c++) begin
            logic [31:0] ins, pc, r1, r2, wd;
            logic        we, j, h;
            logic [4:0]  wa;
            ins = rand_instr(); pc = $urandom; r1 = $urandom; r2 = $urandom; wd = $urandom;
            we  = 1'($urandom_range(0, 1));
            wa  = ($urandom_range(0, 1) == 0) ? ins[19:15] : 5'($urandom);
            j   = ($urandom_range(0, 7) == 0);
            h   = ($urandom_range(0, 5) == 0);
            drive(ins, pc, r1, r2, we, wa, wd, j, h);
            if (j) begin
                exp_r = ref_bubble(pc); sq_m = FLUSH;
            end else if (h) begin
                exp_r = exp_r;
            end else if (sq_m > 0) begin
                exp_r = ref_bubble(pc); sq_m--;
            end else begin
                exp_r = ref_decode(ins, pc, r1, r2, we, wa, wd);
            end
            tick();
            check_out($sformatf("rand%0d", c), exp_r);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
